// File: rtl/axi_lite_initiator.sv
// axi_lite_initiator: turns a single-outstanding core request into one AXI4-Lite
// read or write transaction, returning the data and an error flag to the core.
module axi_lite_initiator #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_wstrb,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_err,
    output logic [ADDR_W-1:0]   araddr,
    output logic                arvalid,
    input  logic                arready,
    input  logic [DATA_W-1:0]   rdata,
    input  logic [1:0]          rresp,
    input  logic                rvalid,
    output logic                rready,
    output logic [ADDR_W-1:0]   awaddr,
    output logic                awvalid,
    input  logic                awready,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wvalid,
    input  logic                wready,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready
);
    typedef enum logic [2:0] {IDLE, RADDR, RDATA, WRITE, WRESP, RESP} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;
    logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
    logic                err_q, err_d, aw_done_q, aw_done_d, w_done_q, w_done_d;

    assign req_ready  = (state_q == IDLE) && rst;
    assign resp_valid = state_q == RESP;
    assign arvalid    = state_q == RADDR;
    assign rready     = state_q == RDATA;
    assign awvalid    = (state_q == WRITE) && !aw_done_q;
    assign wvalid     = (state_q == WRITE) && !w_done_q;
    assign bready     = state_q == WRESP;
    assign araddr     = addr_q;
    assign awaddr     = addr_q;
    assign wdata      = wdata_q;
    assign wstrb      = wstrb_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        unique case (state_q)
            IDLE: if (req_valid) begin
                addr_d  = req_addr;
                wdata_d = req_wdata;
                wstrb_d = req_wstrb;
                state_d = req_we ? WRITE : RADDR;
            end
            RADDR: state_d = arready ? RDATA : RADDR;
            RDATA: if (rvalid) begin
                rdata_d = rdata;
                err_d   = rresp[1];
                state_d = RESP;
            end
            WRITE: begin
                // a ready seen after its channel is done is ignored by the sticky OR
                aw_done_d = aw_done_q || awready;
                w_done_d  = w_done_q || wready;
                if (aw_done_d && w_done_d) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = WRESP;
                end
            end
            WRESP: if (bvalid) begin
                rdata_d = '0;
                err_d   = bresp[1];
                state_d = RESP;
            end
            RESP: state_d = resp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end
endmodule

// File: tb/tb_axi_lite_initiator.sv
// tb_axi_lite_initiator: directed and randomized transactions against an 8-word
// slave memory, checked against a request-level reference memory.
module tb_axi_lite_initiator;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 0, req_we = 0, resp_ready = 0;
    logic [31:0] req_addr = 0, req_wdata = 0;
    logic [3:0]  req_wstrb = 0;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata, araddr, awaddr, wdata;
    logic [3:0]  wstrb;
    logic        arvalid, rready, awvalid, wvalid, bready;
    logic        arready = 0, rvalid = 0, awready = 0, wready = 0, bvalid = 0;
    logic [31:0] rdata = 0;
    logic [1:0]  rresp = 0, bresp = 0;

    int          vec = 0;
    int          err = 0;
    logic [31:0] slv_mem [8];
    logic [31:0] ref_mem [8];
    logic [31:0] last_d = 0;
    logic        last_e = 0;

    axi_lite_initiator #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string t, input logic [31:0] o, input logic [31:0] e);
        vec++;
        assert (o === e) else begin
            err++;
            $error("FAIL %s: observed %h expected %h", t, o, e);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    task automatic resp_phase(input logic [31:0] ed, input logic ee, input int pw);
        for (int i = 0; i <= pw; i++) begin
            resp_ready = (i == pw);
            @(negedge clk);
            chk("resp_valid", resp_valid, 1);
            chk("resp_rdata", resp_rdata, ed);
            chk("resp_err", resp_err, ee);
            chk("resp req_ready", req_ready, 0);
            chk("resp rready", rready, 0);
            chk("resp bready", bready, 0);
            @(posedge clk); #1;
        end
        resp_ready = 0;
        last_d = ed;
        last_e = ee;
    endtask

    task automatic rd(input logic [31:0] a, input int aw, input int rw, input int pw, input logic [1:0] rr);
        logic [31:0] ed, sa;
        ed = ref_mem[a[4:2]];
        sa = 0;
        req_valid = 1; req_we = 0; req_addr = a; req_wdata = $urandom; req_wstrb = 4'($urandom);
        @(negedge clk);
        chk("rd req_ready", req_ready, 1);
        chk("rd idle resp_valid", resp_valid, 0);
        @(posedge clk); #1;
        req_valid = 0;
        for (int i = 0; i <= aw; i++) begin
            arready = (i == aw);
            @(negedge clk);
            chk("arvalid", arvalid, 1);
            chk("araddr", araddr, a);
            chk("raddr rready", rready, 0);
            chk("raddr resp_valid", resp_valid, 0);
            if (arvalid && arready) sa = araddr;
            @(posedge clk); #1;
        end
        arready = 0;
        for (int i = 0; i <= rw; i++) begin
            rvalid = (i == rw);
            rdata  = (i == rw) ? slv_mem[sa[4:2]] : $urandom;
            rresp  = (i == rw) ? rr : 2'($urandom);
            @(negedge clk);
            chk("rready", rready, 1);
            chk("rdata arvalid", arvalid, 0);
            chk("rdata req_ready", req_ready, 0);
            @(posedge clk); #1;
        end
        rvalid = 0;
        resp_phase(ed, rr[1], pw);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input int aww, input int ww, input int bw, input int pw,
                      input logic [1:0] br, input bit stray);
        logic [31:0] sa, sd;
        logic [3:0]  ss;
        bit          ad, wd;
        ad = 0; wd = 0; sa = 0; sd = 0; ss = 0;
        req_valid = 1; req_we = 1; req_addr = a; req_wdata = d; req_wstrb = s;
        @(negedge clk);
        chk("wr req_ready", req_ready, 1);
        chk("wr idle resp_valid", resp_valid, 0);
        @(posedge clk); #1;
        req_valid = 0;
        for (int c = 1; c < 64 && !(ad && wd); c++) begin
            awready = (c > aww);
            wready  = (c > ww);
            rvalid  = stray; rdata = $urandom; rresp = 2'b11;
            bvalid  = stray; bresp = {~br[1], 1'b0};
            @(negedge clk);
            chk("awvalid", awvalid, 32'(!ad));
            chk("wvalid", wvalid, 32'(!wd));
            chk("write bready", bready, 0);
            chk("write resp_valid", resp_valid, 0);
            chk("write req_ready", req_ready, 0);
            if (!ad) chk("awaddr", awaddr, a);
            if (!wd) begin
                chk("wdata", wdata, d);
                chk("wstrb", wstrb, 32'(s));
            end
            if (awvalid && awready) begin sa = awaddr; ad = 1; end
            if (wvalid && wready) begin sd = wdata; ss = wstrb; wd = 1; end
            @(posedge clk); #1;
        end
        chk("aw/w both done", {30'b0, ad, wd}, 3);
        awready = 0; wready = 0; rvalid = 0;
        for (int i = 0; i <= bw; i++) begin
            bvalid = (i == bw);
            bresp  = (i == bw) ? br : 2'b11;
            @(negedge clk);
            chk("bready", bready, 1);
            chk("wresp awvalid", awvalid, 0);
            chk("wresp wvalid", wvalid, 0);
            @(posedge clk); #1;
        end
        bvalid = 0;
        slv_mem[sa[4:2]] = merge(slv_mem[sa[4:2]], sd, ss);
        ref_mem[a[4:2]]  = merge(ref_mem[a[4:2]], d, s);
        resp_phase(32'h0, br[1], pw);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            slv_mem[i] = $urandom;
            ref_mem[i] = slv_mem[i];
        end
        slv_mem[4] = 32'hDEAD_BEEF;
        ref_mem[4] = 32'hDEAD_BEEF;
        #2;
        chk("reset req_ready", req_ready, 0);
        chk("reset resp_valid", resp_valid, 0);
        chk("reset arvalid", arvalid, 0);
        chk("reset awvalid", awvalid, 0);
        chk("reset wvalid", wvalid, 0);
        chk("reset rready", rready, 0);
        chk("reset bready", bready, 0);
        chk("reset araddr", araddr, 0);
        chk("reset resp_rdata", resp_rdata, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1;

        rd(32'h8000_0010, 0, 0, 0, 2'b00);
        wr(32'hA000_03F8, 32'h41, 4'b0001, 3, 0, 0, 0, 2'b00, 0);
        rd(32'h8000_0008, 1, 2, 0, 2'b11);
        wr(32'h8000_0004, 32'h1122_3344, 4'b1010, 0, 2, 1, 0, 2'b10, 0);
        rd(32'h8000_0018, 0, 0, 5, 2'b00);

        rvalid = 1; bvalid = 1; rdata = 32'h1234_5678; rresp = 2'b11; bresp = 2'b11;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stray idle rdata", resp_rdata, last_d);
            chk("stray idle err", resp_err, last_e);
            chk("stray idle resp_valid", resp_valid, 0);
            chk("stray idle req_ready", req_ready, 1);
            @(posedge clk); #1;
            rvalid = 0; bvalid = 0;
        end
        wr(32'h8000_0000, 32'hCAFE_F00D, 4'b0000, 1, 1, 0, 0, 2'b00, 1);
        wr(32'h8000_001C, 32'h5A5A_A5A5, 4'b1111, 2, 0, 0, 0, 2'b01, 1);

        req_valid = 1; req_we = 1; req_addr = 32'h8000_000C; req_wdata = 32'hFFFF_FFFF; req_wstrb = 4'hF;
        @(posedge clk); #1;
        req_valid = 0; awready = 0; wready = 0;
        @(negedge clk);
        chk("pre-reset awvalid", awvalid, 1);
        chk("pre-reset wvalid", wvalid, 1);
        #2 rst = 0;
        #1;
        chk("async rst awvalid", awvalid, 0);
        chk("async rst wvalid", wvalid, 0);
        chk("async rst req_ready", req_ready, 0);
        chk("async rst awaddr", awaddr, 0);
        chk("async rst wdata", wdata, 0);
        chk("async rst resp_rdata", resp_rdata, 0);
        @(posedge clk); #1;
        rst = 1;
        @(negedge clk);
        chk("post-reset req_ready", req_ready, 1);
        chk("post-reset awvalid", awvalid, 0);
        @(posedge clk); #1;
        rd(32'h8000_000C, 0, 0, 0, 2'b00);

        for (int n = 0; n < 30; n++) begin
            logic [31:0] a;
            a = 32'h8000_0000 | (32'($urandom_range(0, 7)) << 2);
            if ($urandom_range(0, 1) == 1)
                wr(a, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 2), $urandom_range(0, 2), 2'($urandom), 1'($urandom));
            else
                rd(a, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), 2'($urandom));
        end
        for (int i = 0; i < 8; i++) rd(32'h8000_0000 | (32'(i) << 2), 0, 0, 0, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule
